aes_byte_loader: RTL and testbench

- Byte-serial front end that sits directly upstream of the AES-128 cipher core.
- Accepts an 8-bit command/data stream and assembles the 128-bit key and plaintext from 16-byte bursts.
- Hands the assembled key and plaintext, with a start request, to the cipher over a valid/ready handshake.
- Replaces the constant-wired key and plaintext currently feeding the cipher.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_byte_loader_if.sv | 34 +++
 rtl/aes_shift_in128.sv | 51 +++++
 rtl/aes_byte_loader.sv | 203 ++++++++++++++++++++
 tb/tb_aes_byte_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte-serial loader.
//   - AES_W / AES_NBYTES : AES-128 block width in bits and bytes
//   - cmd_e              : command tag carried with every input byte
//   - state_e            : loader FSM states
package aes_pkg;

  localparam int AES_W      = 128;
  localparam int AES_NBYTES = 16;

  typedef enum logic [1:0] {
    CMD_ID = 2'b00,  // no-op
    CMD_ST = 2'b01,  // start an encryption
    CMD_SK = 2'b10,  // key byte
    CMD_SP = 2'b11   // plaintext byte
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD_K = 2'b01,
    S_LOAD_P = 2'b10,
    S_START  = 2'b11
  } state_e;

endpackage

// File: rtl/aes_byte_loader_if.sv
// Bus between the byte-stream source / cipher core and aes_byte_loader.
//   din, cmd, din_valid, din_ready : byte stream with valid/ready
//   key_out, text_out              : last completely loaded key / plaintext
//   start_valid, start_ready       : start request to the cipher
//   key_loaded, text_loaded        : status flags
//   err                            : one-cycle protocol error pulse
// master = upstream source and cipher side, slave = the loader.
interface aes_byte_loader_if #(
  parameter int NBYTES = aes_pkg::AES_NBYTES
);

  logic [7:0]          din;
  logic [1:0]          cmd;
  logic                din_valid;
  logic                din_ready;
  logic [8*NBYTES-1:0] key_out;
  logic [8*NBYTES-1:0] text_out;
  logic                start_valid;
  logic                start_ready;
  logic                key_loaded;
  logic                text_loaded;
  logic                err;

  modport master (
    output din, cmd, din_valid, start_ready,
    input  din_ready, key_out, text_out, start_valid, key_loaded, text_loaded, err
  );

  modport slave (
    input  din, cmd, din_valid, start_ready,
    output din_ready, key_out, text_out, start_valid, key_loaded, text_loaded, err
  );

endinterface

// File: rtl/aes_shift_in128.sv
// Byte shift register that assembles one AES block, first byte in the
// least significant position.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : discard the partial block (combined with shift: restart it)
//   shift     : take din as the next byte
//   din       : incoming byte
//   data_next : block as it will look after shifting din in
//   full      : the next shift delivers the final byte of the block
// Only NBYTES-1 bytes are stored: the final byte goes straight from din
// into data_next, which the owner captures on that same edge.
module aes_shift_in128 #(
  parameter int NBYTES = aes_pkg::AES_NBYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift,
  input  logic [7:0]          din,
  output logic [8*NBYTES-1:0] data_next,
  output logic                full
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES < 2) ? 1 : $clog2(NBYTES);

  logic [W-9:0]  hold;
  logic [W-9:0]  hold_base;
  logic [CW-1:0] count;
  logic [CW-1:0] count_base;

  always_comb begin
    hold_base  = clr ? '0 : hold;
    count_base = clr ? '0 : count;
    data_next  = {din, hold_base};
    full       = (count == CW'(NBYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold  <= '0;
      count <= '0;
    end else if (shift) begin
      hold  <= data_next[W-1:8];
      count <= (count_base == CW'(NBYTES - 1)) ? '0 : count_base + CW'(1);
    end else if (clr) begin
      hold  <= '0;
      count <= '0;
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial front end for the AES-128 cipher core. Assembles key and
// plaintext from tagged 16-byte bursts and requests encryption with a
// valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : aes_byte_loader_if.slave (byte stream in, key/text/start out)
// Parameters: NBYTES bytes per block, TIMEOUT idle cycles allowed between
// bytes of a burst (0 = never abort on idle).
module aes_byte_loader
  import aes_pkg::*;
#(
  parameter int NBYTES  = AES_NBYTES,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  aes_byte_loader_if.slave bus
);

  localparam int W  = 8 * NBYTES;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e        state;
  state_e        next_state;
  cmd_e          cmd;
  logic          beat;
  logic          loading;
  logic          tmo_hit;

  logic          k_clr;
  logic          k_shift;
  logic          k_full;
  logic [W-1:0]  k_next;
  logic          p_clr;
  logic          p_shift;
  logic          p_full;
  logic [W-1:0]  p_next;

  logic          key_commit;
  logic          text_commit;
  logic          handoff;
  logic          err_ev;

  logic [W-1:0]  key_q;
  logic [W-1:0]  text_q;
  logic          key_loaded_q;
  logic          text_loaded_q;
  logic          start_valid_q;
  logic          err_q;
  logic [TW-1:0] tcnt;

  assign cmd     = cmd_e'(bus.cmd);
  assign beat    = bus.din_valid & bus.din_ready;
  assign loading = (state == S_LOAD_K) || (state == S_LOAD_P);
  // Abort when the idle cycle about to elapse is the TIMEOUT-th in a row.
  assign tmo_hit = (TIMEOUT != 0) && loading && !beat && (tcnt == TW'(TIMEOUT - 1));

  aes_shift_in128 #(.NBYTES(NBYTES)) u_key_sr (
    .clk       (clk),
    .rst       (rst),
    .clr       (k_clr),
    .shift     (k_shift),
    .din       (bus.din),
    .data_next (k_next),
    .full      (k_full)
  );

  aes_shift_in128 #(.NBYTES(NBYTES)) u_text_sr (
    .clk       (clk),
    .rst       (rst),
    .clr       (p_clr),
    .shift     (p_shift),
    .din       (bus.din),
    .data_next (p_next),
    .full      (p_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and datapath strobes
  always_comb begin
    next_state  = state;
    k_clr       = 1'b0;
    k_shift     = 1'b0;
    p_clr       = 1'b0;
    p_shift     = 1'b0;
    key_commit  = 1'b0;
    text_commit = 1'b0;
    handoff     = 1'b0;
    err_ev      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (beat) begin
          unique case (cmd)
            CMD_SK: begin
              k_clr      = 1'b1;
              k_shift    = 1'b1;
              next_state = S_LOAD_K;
            end
            CMD_SP: begin
              p_clr      = 1'b1;
              p_shift    = 1'b1;
              next_state = S_LOAD_P;
            end
            CMD_ST: begin
              if (key_loaded_q && text_loaded_q) next_state = S_START;
              else                               err_ev     = 1'b1;
            end
            CMD_ID: ;
          endcase
        end
      end
      S_LOAD_K: begin
        if (beat) begin
          if (cmd == CMD_SK) begin
            k_shift = 1'b1;
            if (k_full) begin
              key_commit = 1'b1;
              next_state = S_IDLE;
            end
          end else begin
            // Foreign command aborts the burst; the beat itself is dropped.
            err_ev     = 1'b1;
            k_clr      = 1'b1;
            next_state = S_IDLE;
          end
        end else if (tmo_hit) begin
          err_ev     = 1'b1;
          k_clr      = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_LOAD_P: begin
        if (beat) begin
          if (cmd == CMD_SP) begin
            p_shift = 1'b1;
            if (p_full) begin
              text_commit = 1'b1;
              next_state  = S_IDLE;
            end
          end else begin
            err_ev     = 1'b1;
            p_clr      = 1'b1;
            next_state = S_IDLE;
          end
        end else if (tmo_hit) begin
          err_ev     = 1'b1;
          p_clr      = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_START: begin
        if (bus.start_ready) begin
          handoff    = 1'b1;
          next_state = S_IDLE;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.din_ready   = !rst && (state != S_START);
    bus.start_valid = start_valid_q;
    bus.key_out     = key_q;
    bus.text_out    = text_q;
    bus.key_loaded  = key_loaded_q;
    bus.text_loaded = text_loaded_q;
    bus.err         = err_q;
  end

  // Result registers, status flags and the inter-byte idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q         <= '0;
      text_q        <= '0;
      key_loaded_q  <= 1'b0;
      text_loaded_q <= 1'b0;
      start_valid_q <= 1'b0;
      err_q         <= 1'b0;
      tcnt          <= '0;
    end else begin
      err_q         <= err_ev;
      start_valid_q <= (next_state == S_START);
      if (key_commit) begin
        key_q        <= k_next;
        key_loaded_q <= 1'b1;
      end
      if (text_commit) begin
        text_q        <= p_next;
        text_loaded_q <= 1'b1;
      end else if (handoff) begin
        text_loaded_q <= 1'b0;
      end
      if ((TIMEOUT != 0) && loading && !beat && !tmo_hit) tcnt <= tcnt + TW'(1);
      else                                                 tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: two instances (TIMEOUT=4 and TIMEOUT=0) share
// one input stream; a byte-list model predicts every output every cycle.
module tb_aes_byte_loader;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [1:0] cmd;
  logic       vin;
  logic       sr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_byte_loader_if #(.NBYTES(16)) bus_a ();
  aes_byte_loader_if #(.NBYTES(16)) bus_b ();

  assign bus_a.din = din;   assign bus_b.din = din;
  assign bus_a.cmd = cmd;   assign bus_b.cmd = cmd;
  assign bus_a.din_valid = vin;  assign bus_b.din_valid = vin;
  assign bus_a.start_ready = sr; assign bus_b.start_ready = sr;

  aes_byte_loader #(.NBYTES(16), .TIMEOUT(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  aes_byte_loader #(.NBYTES(16), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // ---------------- reference model ----------------
  // mode: 0 waiting for a command, 1 collecting key bytes,
  //       2 collecting plaintext bytes, 3 waiting for the cipher
  int           m_mode [2];
  int           m_n    [2];
  int           m_idle [2];
  logic [7:0]   m_part [2][16];
  logic [127:0] m_key  [2];
  logic [127:0] m_text [2];
  bit           m_kl [2], m_tl [2], m_err [2], m_sv [2];

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic logic [127:0] assemble(input int k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m_part[k][i];
    return r;
  endfunction

  task automatic model_step(input int k);
    bit beat;
    logic [1:0] want;
    m_err[k] = 1'b0;
    if (rst) begin
      m_mode[k] = 0; m_n[k] = 0; m_idle[k] = 0;
      m_key[k] = '0; m_text[k] = '0;
      m_kl[k] = 1'b0; m_tl[k] = 1'b0; m_sv[k] = 1'b0;
      return;
    end
    beat = vin && (m_mode[k] != 3);
    case (m_mode[k])
      0: if (beat) begin
        if (cmd == CMD_SK || cmd == CMD_SP) begin
          m_part[k][0] = din; m_n[k] = 1; m_idle[k] = 0;
          m_mode[k] = (cmd == CMD_SK) ? 1 : 2;
        end else if (cmd == CMD_ST) begin
          if (m_kl[k] && m_tl[k]) m_mode[k] = 3;
          else                    m_err[k]  = 1'b1;
        end
      end
      1, 2: begin
        want = (m_mode[k] == 1) ? CMD_SK : CMD_SP;
        if (beat) begin
          m_idle[k] = 0;
          if (cmd == want) begin
            m_part[k][m_n[k]] = din;
            m_n[k]++;
            if (m_n[k] == 16) begin
              if (m_mode[k] == 1) begin m_key[k]  = assemble(k); m_kl[k] = 1'b1; end
              else                begin m_text[k] = assemble(k); m_tl[k] = 1'b1; end
              m_mode[k] = 0; m_n[k] = 0;
            end
          end else begin
            m_err[k] = 1'b1; m_mode[k] = 0; m_n[k] = 0;
          end
        end else begin
          m_idle[k]++;
          if (tmo(k) != 0 && m_idle[k] == tmo(k)) begin
            m_err[k] = 1'b1; m_mode[k] = 0; m_n[k] = 0; m_idle[k] = 0;
          end
        end
      end
      default: if (sr) begin m_tl[k] = 1'b0; m_mode[k] = 0; end
    endcase
    m_sv[k] = (m_mode[k] == 3);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic dr, input logic sv, input logic kl,
                     input logic tl, input logic er, input logic [127:0] ko,
                     input logic [127:0] to);
    chk($sformatf("din_ready[%0d]", k),   dr, !rst && (m_mode[k] != 3));
    chk($sformatf("start_valid[%0d]", k), sv, m_sv[k]);
    chk($sformatf("key_loaded[%0d]", k),  kl, m_kl[k]);
    chk($sformatf("text_loaded[%0d]", k), tl, m_tl[k]);
    chk($sformatf("err[%0d]", k),         er, m_err[k]);
    chk($sformatf("key_out[%0d]", k),     ko, m_key[k]);
    chk($sformatf("text_out[%0d]", k),    to, m_text[k]);
  endtask

  always @(negedge clk) begin
    cmp(0, bus_a.din_ready, bus_a.start_valid, bus_a.key_loaded, bus_a.text_loaded,
        bus_a.err, bus_a.key_out, bus_a.text_out);
    cmp(1, bus_b.din_ready, bus_b.start_valid, bus_b.key_loaded, bus_b.text_loaded,
        bus_b.err, bus_b.key_out, bus_b.text_out);
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] c, input logic [7:0] d);
    vin = 1'b1; cmd = c; din = d;
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [1:0] c, output logic [127:0] v);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      v[8*i +: 8] = b;
      send(c, b);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1, t1, k2, t2, t3, k3;
    logic [1:0]   fav;
    rst = 1'b1; vin = 1'b0; cmd = CMD_ID; din = 8'h00; sr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_ready", bus_a.din_ready, 1'b0);
    chk("rst_key_out", bus_a.key_out, 128'h0);
    chk("rst_start_valid", bus_a.start_valid, 1'b0);
    rst = 1'b0;

    // ST with nothing loaded
    send(CMD_ST, 8'h00);
    chk("st_nodata_err", bus_a.err, 1'b1);
    chk("st_nodata_sv", bus_a.start_valid, 1'b0);
    idle(1);
    chk("st_nodata_err_clear", bus_a.err, 1'b0);

    // zero key, plaintext with top byte 0x80, single-cycle start
    repeat (16) send(CMD_SK, 8'h00);
    repeat (15) send(CMD_SP, 8'h00);
    send(CMD_SP, 8'h80);
    chk("load_key_out", bus_a.key_out, 128'h0);
    chk("load_text_out", bus_a.text_out, {8'h80, 120'h0});
    chk("model_text_pin", m_text[0], {8'h80, 120'h0});
    chk("load_text_loaded", bus_a.text_loaded, 1'b1);
    sr = 1'b1;
    send(CMD_ST, 8'h00);
    chk("start_sv_high", bus_a.start_valid, 1'b1);
    idle(1);
    chk("start_sv_low", bus_a.start_valid, 1'b0);
    chk("start_text_loaded", bus_a.text_loaded, 1'b0);
    chk("start_key_loaded", bus_a.key_loaded, 1'b1);

    // byte order
    for (int i = 0; i < 16; i++) send(CMD_SK, 8'(i));
    k1 = 128'h0F0E0D0C0B0A09080706050403020100;
    chk("order_key_out", bus_a.key_out, k1);
    chk("model_key_pin", m_key[0], k1);

    // cipher backpressure
    burst(CMD_SP, t1);
    sr = 1'b0;
    send(CMD_ST, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("bp_sv", bus_a.start_valid, 1'b1);
      chk("bp_din_ready", bus_a.din_ready, 1'b0);
      chk("bp_key_stable", bus_a.key_out, k1);
      chk("bp_text_stable", bus_a.text_out, t1);
      @(posedge clk); #1;
    end
    sr = 1'b1;
    chk("bp_sv_6th", bus_a.start_valid, 1'b1);
    @(posedge clk); #1;
    chk("bp_handoff", bus_a.start_valid, 1'b0);
    chk("bp_text_loaded", bus_a.text_loaded, 1'b0);

    // mismatched command mid-burst
    repeat (7) send(CMD_SK, 8'($urandom));
    send(CMD_SP, 8'h5A);
    chk("abort_err", bus_a.err, 1'b1);
    chk("abort_key_kept", bus_a.key_out, k1);
    chk("abort_din_ready", bus_a.din_ready, 1'b1);
    idle(1);
    chk("abort_err_clear", bus_a.err, 1'b0);
    burst(CMD_SK, k2);
    chk("reload_key_out", bus_a.key_out, k2);

    // idle timeout (instance a) versus no timeout (instance b)
    burst(CMD_SP, t2);
    chk("tmo_text_loaded_pre", bus_a.text_loaded, 1'b1);
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      t3[8*i +: 8] = din;
      send(CMD_SP, din);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("tmo_no_err_yet", bus_a.err, 1'b0);
    end
    @(posedge clk); #1;
    chk("tmo_err", bus_a.err, 1'b1);
    chk("tmo_text_loaded", bus_a.text_loaded, 1'b1);
    chk("tmo_text_kept", bus_a.text_out, t2);
    chk("notmo_err", bus_b.err, 1'b0);
    idle(1000);
    for (int i = 3; i < 16; i++) begin
      din = 8'($urandom);
      t3[8*i +: 8] = din;
      send(CMD_SP, din);
    end
    chk("notmo_text_out", bus_b.text_out, t3);
    chk("notmo_text_loaded", bus_b.text_loaded, 1'b1);
    send(CMD_ID, 8'h00);
    chk("id_abort_err_a", bus_a.err, 1'b1);
    chk("id_idle_err_b", bus_b.err, 1'b0);

    // reset in the middle of a key burst
    repeat (10) send(CMD_SK, 8'($urandom));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_key_loaded", bus_a.key_loaded, 1'b0);
    chk("midrst_key_out", bus_a.key_out, 128'h0);
    rst = 1'b0;
    burst(CMD_SK, k3);
    chk("postrst_key_out", bus_a.key_out, k3);
    chk("postrst_key_out_b", bus_b.key_out, k3);

    // random traffic
    fav = CMD_SK;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) fav = 2'($urandom_range(1, 3));
      vin = ($urandom_range(0, 3) != 0);
      cmd = ($urandom_range(0, 19) == 0) ? 2'($urandom) : fav;
      din = 8'($urandom);
      sr  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) begin
        vin = 1'b0;
        repeat (5) @(posedge clk);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
